// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a memory-wait timeout.
// It also has a sticky ERROR state that only reset can leave.
module multicycle_control #(
  parameter int unsigned ALU_FUNC_W  = 6,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [5:0]            opcode_in,
  input  logic [5:0]            func_in,
  input  logic                  data_mem_ready_in,
  output logic                  pc_enable_out,
  output logic                  ir_we_out,
  output logic                  regfile_we_out,
  output logic                  alu_mux_select_out,
  output logic [ALU_FUNC_W-1:0] alu_func_out,
  output logic                  data_mem_re_out,
  output logic                  data_mem_we_out,
  output logic [1:0]            data_mem_size_out,
  output logic                  data_mem_mux_select_out,
  output logic [2:0]            state_out,
  output logic                  error_out
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   fn_q, fn_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              is_rtype_c;
  logic              is_load_c;
  logic              is_store_c;
  logic [OP_W-1:0]   alu_fn_c;
  logic [1:0]        mem_size_c;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b100000, 6'b100001,
      6'b100011, 6'b101000, 6'b101001, 6'b101011: op_supported = 1'b1;
      default:                                    op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic func_supported(input logic [OP_W-1:0] fn);
    case (fn)
      6'b100000, 6'b100001, 6'b100010, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b101010: func_supported = 1'b1;
      default:                                    func_supported = 1'b0;
    endcase
  endfunction

  // Loads are 100xxx and stores 101xxx; the low two opcode bits select the size.
  assign is_rtype_c = (op_q == '0);
  assign is_load_c  = op_q[5] & ~op_q[3];
  assign is_store_c = op_q[5] & op_q[3];
  assign alu_fn_c   = is_rtype_c ? fn_q : 6'b100000;

  always_comb begin
    case (op_q[1:0])
      2'b00:   mem_size_c = 2'b01;
      2'b01:   mem_size_c = 2'b10;
      default: mem_size_c = 2'b11;
    endcase
  end

  // State register and instruction latches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; the timeout compare fires on the cycle the counter would reach MEM_TIMEOUT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    wait_d  = wait_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode_in;
        fn_d = func_in;
        if (!op_supported(opcode_in) ||
            ((opcode_in == '0) && !func_supported(func_in))) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = op_q[5] ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (data_mem_ready_in) begin
          state_d = is_load_c ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:     state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  // Output decode; gated by reset so strobes drop the moment reset asserts.
  always_comb begin
    pc_enable_out           = 1'b0;
    ir_we_out               = 1'b0;
    regfile_we_out          = 1'b0;
    alu_mux_select_out      = 1'b0;
    alu_func_out            = '0;
    data_mem_re_out         = 1'b0;
    data_mem_we_out         = 1'b0;
    data_mem_size_out       = 2'b00;
    data_mem_mux_select_out = 1'b0;
    state_out               = 3'd0;
    error_out               = 1'b0;
    if (rst_n_in) begin
      state_out = state_q;
      case (state_q)
        S_FETCH: ir_we_out = 1'b1;
        S_EXEC: begin
          alu_func_out       = ALU_FUNC_W'(alu_fn_c);
          alu_mux_select_out = ~is_rtype_c;
        end
        S_MEM: begin
          alu_func_out       = ALU_FUNC_W'(alu_fn_c);
          alu_mux_select_out = ~is_rtype_c;
          data_mem_re_out    = is_load_c;
          data_mem_we_out    = is_store_c;
          data_mem_size_out  = mem_size_c;
          pc_enable_out      = is_store_c & data_mem_ready_in;
        end
        S_WB: begin
          alu_func_out            = ALU_FUNC_W'(alu_fn_c);
          alu_mux_select_out      = ~is_rtype_c;
          regfile_we_out          = 1'b1;
          pc_enable_out           = 1'b1;
          data_mem_mux_select_out = is_load_c;
        end
        S_ERROR: error_out = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have parameter ALU_FUNC_W, default 6, giving the width of the ALU function code; values below 6 are unsupported.
REQ-002 The module SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum MEM-state wait cycles before an error is raised; legal range is 1 to 255.
REQ-003 The module SHALL have port clk_in, input, width 1: the single clock, with all state changing on its rising edge.
REQ-004 The module SHALL have port rst_n_in, input, width 1: reset, asynchronous and active-low.
REQ-005 The module SHALL have port opcode_in, input, width 6: the instruction opcode from the instruction register.
REQ-006 The module SHALL have port func_in, input, width 6: the R-type function field.
REQ-007 The module SHALL have port data_mem_ready_in, input, width 1: the data memory has completed the current access.
REQ-008 The module SHALL have outputs pc_enable_out, ir_we_out, regfile_we_out, alu_mux_select_out, data_mem_re_out, data_mem_we_out and data_mem_mux_select_out, each width 1.
REQ-009 The module SHALL have output alu_func_out, width ALU_FUNC_W, carrying the function code, zero-extended, on the low 6 bits.
REQ-010 The module SHALL have output data_mem_size_out, width 2: 00 idle, 01 byte, 10 half, 11 word.
REQ-011 The module SHALL have output state_out, width 3, and output error_out, width 1 (sticky).

Function
REQ-012 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7.
REQ-013 FETCH SHALL assert ir_we_out for one cycle and then go to DECODE.
REQ-014 DECODE SHALL latch opcode_in and func_in into internal registers and go to EXEC; later input changes SHALL be ignored until the next DECODE.
REQ-015 In DECODE, an unsupported opcode (anything other than 000000, 001000, 100000, 100001, 100011, 101000, 101001, 101011) SHALL go to ERROR instead of EXEC.
REQ-016 In DECODE, opcode 000000 with a func outside {100000, 100001, 100010, 100100, 100101, 100110, 100111, 101010} SHALL go to ERROR.
REQ-017 alu_func_out SHALL equal the latched func for R-type and 100000 for addi, loads and stores; it SHALL hold its value from EXEC through WB.
REQ-018 alu_mux_select_out SHALL be 0 for R-type and 1 (immediate) for all other opcodes, from EXEC through WB.
REQ-019 EXEC SHALL go to WB for R-type and addi, and to MEM for loads and stores.
REQ-020 In MEM, data_mem_re_out (loads) or data_mem_we_out (stores) SHALL be held high, with data_mem_size_out set from the opcode.
REQ-021 The MEM size mapping SHALL be: 100000/101000 byte, 100001/101001 half, 100011/101011 word; data_mem_size_out SHALL be 00 outside MEM.
REQ-022 MEM SHALL exit on the cycle data_mem_ready_in is sampled high: loads go to WB, stores go to FETCH with pc_enable_out pulsed that cycle.
REQ-023 A wait counter SHALL clear on MEM entry and increment each MEM cycle with data_mem_ready_in low.
REQ-024 If the wait counter reaches MEM_TIMEOUT with data_mem_ready_in still low, the FSM SHALL go to ERROR; if data_mem_ready_in is high on that same cycle, ready SHALL win.
REQ-025 WB SHALL assert regfile_we_out and pc_enable_out for one cycle, then go to FETCH.
REQ-026 data_mem_mux_select_out SHALL be 1 in WB for loads and 0 otherwise.
REQ-027 Latency SHALL be: R-type/addi 4 cycles per instruction; load 5+N cycles; store 4+N cycles, where N is the number of wait cycles.
REQ-028 ERROR SHALL force every enable and strobe output low and error_out high, and SHALL be left only by reset.
REQ-029 pc_enable_out, regfile_we_out and data_mem_we_out SHALL never be high in FETCH, DECODE or ERROR.

Reset
REQ-030 While rst_n_in is low, the FSM SHALL be in FETCH, all outputs SHALL be 0 (alu_func_out 0, state_out 0, error_out 0), and the latched fields and wait counter SHALL be 0.
REQ-031 Reset asserted mid-MEM SHALL drop data_mem_we_out and data_mem_re_out asynchronously, with no completion pulse.
REQ-032 On the first rising clk_in edge after rst_n_in rises, the FSM SHALL execute FETCH.

Verification
REQ-033 The bench SHALL check: opcode 000000, func 100010 -> states 0,1,2,4,0; alu_func_out=100010, alu_mux_select_out=0; regfile_we_out and pc_enable_out high only in state 4.
REQ-034 The bench SHALL check: opcode 100011 with ready low for 3 cycles -> data_mem_re_out high 4 cycles, size=11; WB with data_mem_mux_select_out=1; total 8 cycles.
REQ-035 The bench SHALL check: opcode 101000 with ready high immediately -> one MEM cycle, data_mem_we_out=1, size=01, regfile_we_out never high, pc_enable_out pulse in MEM.
REQ-036 The bench SHALL check: opcode 111111 -> state_out=7 on the cycle after DECODE, error_out=1 held for 20 cycles, all strobes 0.
REQ-037 The bench SHALL check: MEM_TIMEOUT=4 with ready held low -> ERROR entered after exactly 4 MEM cycles; a repeat run with ready on the 4th cycle -> WB, not ERROR.
REQ-038 The bench SHALL check: rst_n_in pulsed low mid-MEM on a store -> data_mem_we_out=0 without a clock edge; restart from FETCH with error_out=0.
